// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO.
//   MODE_STD  : registered read, data appears one cycle after the pop
//   MODE_FWFT : first-word-fall-through, head word is visible without a pop
//   bits_for  : number of bits needed to index n distinct values (at least 1)
package sync_fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    function automatic int bits_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Storage array for sync_fifo_prog: WIDTH x DEPTH registers with one
// synchronous write port and one asynchronous read port. The array is not reset.
//   clk   in  1       write clock, rising edge
//   we    in  1       write enable
//   waddr in  ADDR_W  write address (0 .. DEPTH-1)
//   wdata in  WIDTH   write data
//   raddr in  ADDR_W  read address (0 .. DEPTH-1)
//   rdata out WIDTH   contents of raddr, combinational
module fifo_ram_2p
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [bits_for(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]            wdata,
    input  logic [bits_for(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]            rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth (>= 2), programmable almost-full /
// almost-empty thresholds, live fill count, synchronous flush and a selectable
// read mode (registered or first-word-fall-through).
//   clk_i          in  1      clock, rising edge
//   rst_ni         in  1      asynchronous active-low reset
//   flush_i        in  1      synchronous flush, beats any concurrent write/read
//   wr_en_i        in  1      write request
//   wdata_i        in  WIDTH  write data
//   rd_en_i        in  1      read request (pop in FWFT mode)
//   rdata_o        out WIDTH  read data
//   rvalid_o       out 1      rdata_o holds a valid popped/head word
//   full_o         out 1      count == DEPTH
//   empty_o        out 1      count == 0
//   almost_full_o  out 1      count >= AF_THRESH
//   almost_empty_o out 1      count <= AE_THRESH
//   count_o        out CNT_W  number of stored words
//   wr_error_o     out 1      one-cycle pulse after a rejected write
//   rd_error_o     out 1      one-cycle pulse after a rejected read
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = MODE_STD
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           flush_i,
    input  logic                           wr_en_i,
    input  logic [WIDTH-1:0]               wdata_i,
    input  logic                           rd_en_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic                           rvalid_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           almost_full_o,
    output logic                           almost_empty_o,
    output logic [bits_for(DEPTH+1)-1:0]   count_o,
    output logic                           wr_error_o,
    output logic                           rd_error_o
);

    localparam int PTR_W = bits_for(DEPTH);
    localparam int CNT_W = bits_for(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_err_q;
    logic             rd_err_q;
    logic             full;
    logic             empty;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] mem_rdata;

    assign full   = (count == DEPTH_CNT);
    assign empty  = (count == '0);
    assign rd_acc = rd_en_i & ~empty;
    // A write into a full FIFO is fine when a pop frees a slot in the same cycle.
    assign wr_acc = wr_en_i & (~full | rd_acc);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wr_err_q <= wr_en_i & ~wr_acc;
            rd_err_q <= rd_en_i & ~rd_acc;
        end
    end

    fifo_ram_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk_i),
        .we    (wr_acc & ~flush_i),
        .waddr (wr_ptr),
        .wdata (wdata_i),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is presented directly from the array.
            assign rdata_o  = mem_rdata;
            assign rvalid_o = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] rdata_q;
            logic             rvalid_q;

            // Output register loads only on an accepted pop and holds otherwise,
            // including across a flush.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else if (flush_i) begin
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) begin
                        rdata_q <= mem_rdata;
                    end
                end
            end

            assign rdata_o  = rdata_q;
            assign rvalid_o = rvalid_q;
        end
    endgenerate

    assign full_o         = full;
    assign empty_o        = empty;
    assign almost_full_o  = (count >= AF_CNT);
    assign almost_empty_o = (count <= AE_CNT);
    assign count_o        = count;
    assign wr_error_o     = wr_err_q;
    assign rd_error_o     = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog. Two instances share clock and reset:
//   u_std : WIDTH=8, DEPTH=16, AF=14, AE=2, registered read
//   u_alt : WIDTH=8, DEPTH=12, AF=10, AE=2, first-word-fall-through
module tb_sync_fifo_prog;

    logic       clk;
    logic       rst_n;

    logic       s_flush, s_wr, s_rd;
    logic [7:0] s_wdata, s_rdata;
    logic       s_rvalid, s_full, s_empty, s_af, s_ae, s_wr_err, s_rd_err;
    logic [4:0] s_count;

    logic       a_flush, a_wr, a_rd;
    logic [7:0] a_wdata, a_rdata;
    logic       a_rvalid, a_full, a_empty, a_af, a_ae, a_wr_err, a_rd_err;
    logic [3:0] a_count;

    int total = 0;
    int bad   = 0;

    sync_fifo_prog #(
        .WIDTH (8),
        .DEPTH (16),
        .FWFT  (0)
    ) u_std (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (s_flush),
        .wr_en_i        (s_wr),
        .wdata_i        (s_wdata),
        .rd_en_i        (s_rd),
        .rdata_o        (s_rdata),
        .rvalid_o       (s_rvalid),
        .full_o         (s_full),
        .empty_o        (s_empty),
        .almost_full_o  (s_af),
        .almost_empty_o (s_ae),
        .count_o        (s_count),
        .wr_error_o     (s_wr_err),
        .rd_error_o     (s_rd_err)
    );

    sync_fifo_prog #(
        .WIDTH (8),
        .DEPTH (12),
        .FWFT  (1)
    ) u_alt (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .flush_i        (a_flush),
        .wr_en_i        (a_wr),
        .wdata_i        (a_wdata),
        .rd_en_i        (a_rd),
        .rdata_o        (a_rdata),
        .rvalid_o       (a_rvalid),
        .full_o         (a_full),
        .empty_o        (a_empty),
        .almost_full_o  (a_af),
        .almost_empty_o (a_ae),
        .count_o        (a_count),
        .wr_error_o     (a_wr_err),
        .rd_error_o     (a_rd_err)
    );

    // Free-running 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] time limit reached");
    end

    // Drive one instance for one cycle (other instance idle), then sample 1 ns after the edge
    task automatic applyStimulus(input bit use_alt, input bit f, input bit w,
                                 input logic [7:0] d, input bit r);
        s_flush = use_alt ? 1'b0 : f;
        s_wr    = use_alt ? 1'b0 : w;
        s_wdata = use_alt ? 8'h00 : d;
        s_rd    = use_alt ? 1'b0 : r;
        a_flush = use_alt ? f : 1'b0;
        a_wr    = use_alt ? w : 1'b0;
        a_wdata = use_alt ? d : 8'h00;
        a_rd    = use_alt ? r : 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and on mismatch count the failure and report
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full reset-state check on the standard instance
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_count"}, 32'(s_count), 32'd0);
        checkOutput({tag, "_empty"}, 32'(s_empty), 32'd1);
        checkOutput({tag, "_ae"},    32'(s_ae),    32'd1);
        checkOutput({tag, "_full"},  32'(s_full),  32'd0);
        checkOutput({tag, "_af"},    32'(s_af),    32'd0);
        checkOutput({tag, "_rvalid"},32'(s_rvalid),32'd0);
        checkOutput({tag, "_rdata"}, 32'(s_rdata), 32'd0);
        checkOutput({tag, "_wrerr"}, 32'(s_wr_err),32'd0);
        checkOutput({tag, "_rderr"}, 32'(s_rd_err),32'd0);
    endtask

    // Directed sequence
    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] sb [$];
        bit         w, r, wa, ra;
        logic [7:0] d;

        rst_n = 1'b0;
        s_flush = 0; s_wr = 0; s_wdata = 0; s_rd = 0;
        a_flush = 0; a_wr = 0; a_wdata = 0; a_rd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkResetState("por");

        // Reset dropped during traffic
        applyStimulus(0, 0, 1, 8'h11, 0);
        applyStimulus(0, 0, 1, 8'h22, 0);
        applyStimulus(0, 0, 1, 8'h33, 0);
        checkOutput("pre_count", 32'(s_count), 32'd3);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("pre_rvalid", 32'(s_rvalid), 32'd1);
        checkOutput("pre_rdata",  32'(s_rdata),  32'h11);
        s_wr = 1'b1; s_wdata = 8'h44; s_rd = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("async");
        repeat (3) @(posedge clk);
        #1;
        checkResetState("held");
        s_wr = 1'b0; s_rd = 1'b0; s_wdata = 8'h00;
        rst_n = 1'b1;

        // Fill 16 words, watching the threshold flags
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 1, 8'(i), 0);
            checkOutput("fill_count", 32'(s_count), 32'(i + 1));
            checkOutput("fill_af",    32'(s_af),    32'((i + 1) >= 14));
            checkOutput("fill_full",  32'(s_full),  32'((i + 1) == 16));
            checkOutput("fill_ae",    32'(s_ae),    32'((i + 1) <= 2));
        end
        applyStimulus(0, 0, 1, 8'hEE, 0);
        checkOutput("ovf_wrerr", 32'(s_wr_err), 32'd1);
        checkOutput("ovf_count", 32'(s_count),  32'd16);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("ovf_pulse", 32'(s_wr_err), 32'd0);

        // Drain 16 in order, one-cycle read latency
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 1);
            checkOutput("drain_rvalid", 32'(s_rvalid), 32'd1);
            checkOutput("drain_rdata",  32'(s_rdata),  32'(i));
            checkOutput("drain_count",  32'(s_count),  32'(15 - i));
        end
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("idle_rvalid", 32'(s_rvalid), 32'd0);
        checkOutput("idle_rdata",  32'(s_rdata),  32'h0F);
        checkOutput("idle_empty",  32'(s_empty),  32'd1);

        // Read when empty, then read+write together when empty
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("urd_rderr",  32'(s_rd_err), 32'd1);
        checkOutput("urd_rvalid", 32'(s_rvalid), 32'd0);
        checkOutput("urd_count",  32'(s_count),  32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("urd_pulse",  32'(s_rd_err), 32'd0);
        applyStimulus(0, 0, 1, 8'h5A, 1);
        checkOutput("rw_empty_rderr", 32'(s_rd_err), 32'd1);
        checkOutput("rw_empty_wrerr", 32'(s_wr_err), 32'd0);
        checkOutput("rw_empty_count", 32'(s_count),  32'd1);
        checkOutput("rw_empty_rvld",  32'(s_rvalid), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("rw_empty_data",  32'(s_rdata),  32'h5A);
        checkOutput("rw_empty_rvld2", 32'(s_rvalid), 32'd1);
        checkOutput("rw_empty_cnt2",  32'(s_count),  32'd0);

        // Full, then read+write together
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 1, 8'(8'h80 + i), 0);
        end
        checkOutput("full2_full", 32'(s_full), 32'd1);
        applyStimulus(0, 0, 1, 8'hC0, 1);
        checkOutput("frw_wrerr", 32'(s_wr_err), 32'd0);
        checkOutput("frw_count", 32'(s_count),  32'd16);
        checkOutput("frw_rdata", 32'(s_rdata),  32'h80);
        applyStimulus(0, 0, 1, 8'hC1, 1);
        checkOutput("frw_rdata2", 32'(s_rdata), 32'h81);
        checkOutput("frw_full",   32'(s_full),  32'd1);
        for (int i = 2; i < 16; i++) exp_q.push_back(8'(8'h80 + i));
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 1);
            checkOutput("frw_order", 32'(s_rdata), 32'(exp_q[i]));
        end
        checkOutput("frw_empty", 32'(s_empty), 32'd1);

        // Flush at count 9 with a concurrent write
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 1, 8'(8'h30 + i), 0);
        end
        checkOutput("fl_pre_count", 32'(s_count), 32'd9);
        applyStimulus(0, 1, 1, 8'h99, 0);
        checkOutput("fl_count",  32'(s_count),  32'd0);
        checkOutput("fl_empty",  32'(s_empty),  32'd1);
        checkOutput("fl_wrerr",  32'(s_wr_err), 32'd0);
        checkOutput("fl_rderr",  32'(s_rd_err), 32'd0);
        checkOutput("fl_rvalid", 32'(s_rvalid), 32'd0);
        checkOutput("fl_rdata",  32'(s_rdata),  32'hC1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("fl_dropped", 32'(s_rd_err), 32'd1);

        // FWFT: first write visible without a pop
        checkOutput("fw_idle_rvalid", 32'(a_rvalid), 32'd0);
        applyStimulus(1, 0, 1, 8'hA5, 0);
        checkOutput("fw_rdata",  32'(a_rdata),  32'hA5);
        checkOutput("fw_rvalid", 32'(a_rvalid), 32'd1);
        checkOutput("fw_count",  32'(a_count),  32'd1);
        applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("fw_pop_rvalid", 32'(a_rvalid), 32'd0);
        checkOutput("fw_pop_empty",  32'(a_empty),  32'd1);

        // DEPTH=12 interleaved traffic against a queue model, write-biased so pointers wrap
        for (int i = 0; i < 40; i++) begin
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 1) == 1);
            d = 8'($urandom);
            if (sb.size() > 0) begin
                checkOutput("rnd_head",   32'(a_rdata),  32'(sb[0]));
                checkOutput("rnd_rvalid", 32'(a_rvalid), 32'd1);
            end else begin
                checkOutput("rnd_rvalid", 32'(a_rvalid), 32'd0);
            end
            ra = r && (sb.size() > 0);
            wa = w && ((sb.size() < 12) || ra);
            applyStimulus(1, 0, w, d, r);
            if (ra) void'(sb.pop_front());
            if (wa) sb.push_back(d);
            checkOutput("rnd_count", 32'(a_count),  32'(sb.size()));
            checkOutput("rnd_wrerr", 32'(a_wr_err), 32'(w && !wa));
            checkOutput("rnd_rderr", 32'(a_rd_err), 32'(r && !ra));
            checkOutput("rnd_full",  32'(a_full),   32'(sb.size() == 12));
            checkOutput("rnd_af",    32'(a_af),     32'(sb.size() >= 10));
        end
        for (int i = 0; i < 12 && sb.size() > 0; i++) begin
            checkOutput("rnd_drain", 32'(a_rdata), 32'(sb[0]));
            applyStimulus(1, 0, 0, 8'h00, 1);
            void'(sb.pop_front());
            checkOutput("rnd_drain_cnt", 32'(a_count), 32'(sb.size()));
        end
        checkOutput("rnd_end_empty", 32'(a_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
